// File: rtl/vmicro16_uart_tx_apb_pkg.sv
// Shared definitions for the vmicro16 APB UART transmitter: register offsets,
// STATUS bit positions and serialiser state encoding.
package vmicro16_uart_tx_apb_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/vmicro16_fifo.sv
// Single-clock FIFO, registered state with combinational head (dout); one cycle push-to-visible.
// Push when full is dropped unless a pop happens in the same cycle; pop when empty is ignored.
module vmicro16_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vmicro16_uart_tx_apb.sv
// APB3 slave that queues bytes and serialises them 8N1 LSB-first; tx falls 2 cycles after a write to an idle unit.
// Zero wait states; writes to a full FIFO are dropped and flagged in the sticky overflow bit.
module vmicro16_uart_tx_apb #(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  S_PSELx,
  input  logic                  S_PENABLE,
  input  logic                  S_PWRITE,
  input  logic [1:0]            S_PADDR,
  input  logic [DATA_WIDTH-1:0] S_PWDATA,
  output logic [DATA_WIDTH-1:0] S_PRDATA,
  output logic                  S_PREADY,
  output logic                  uart_tx
);

  import vmicro16_uart_tx_apb_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(CLK_DIV);
  localparam logic [TW-1:0] BIT_LOAD = TW'(CLK_DIV - 1);

  logic          access;
  logic          wr_txdata;
  logic          rd_status;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_dout;
  logic          pop;
  logic          busy;
  logic          ovf;
  logic [7:0]    status;

  tx_state_t     state;
  logic [TW-1:0] timer;
  logic [7:0]    shift;
  logic [2:0]    idx;

  logic unused_pwdata;
  assign unused_pwdata = ^S_PWDATA[DATA_WIDTH-1:8];

  assign access    = S_PSELx & S_PENABLE;
  assign wr_txdata = access & S_PWRITE & (S_PADDR == REG_TXDATA);
  assign rd_status = access & ~S_PWRITE & (S_PADDR == REG_STATUS);
  assign pop       = (state == TX_IDLE) & ~fifo_empty;
  assign busy      = (state != TX_IDLE);
  assign S_PREADY  = 1'b1;

  vmicro16_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_txdata),
    .pop   (pop),
    .din   (S_PWDATA[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A depth-16 FIFO reports count 0 when full; the full bit disambiguates.
  always_comb begin
    status                      = '0;
    status[ST_FULL]             = fifo_full;
    status[ST_EMPTY]            = fifo_empty;
    status[ST_BUSY]             = busy;
    status[ST_OVF]              = ovf;
    status[ST_COUNT_LSB +: 4]   = 4'(fifo_count);
  end

  always_comb begin
    S_PRDATA = '0;
    if (rd_status) S_PRDATA[7:0] = status;
  end

  // A new overflow wins over a clearing read in the same cycle.
  always_ff @(posedge clk) begin
    if (reset)                                ovf <= 1'b0;
    else if (wr_txdata & fifo_full & ~pop)    ovf <= 1'b1;
    else if (rd_status)                       ovf <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= TX_IDLE;
      timer   <= BIT_LOAD;
      shift   <= '0;
      idx     <= '0;
      uart_tx <= 1'b1;
    end else begin
      case (state)
        TX_IDLE: begin
          uart_tx <= 1'b1;
          timer   <= BIT_LOAD;
          if (!fifo_empty) begin
            shift   <= fifo_dout;
            state   <= TX_START;
            uart_tx <= 1'b0;
          end
        end
        TX_START: begin
          if (timer == '0) begin
            state   <= TX_DATA;
            idx     <= '0;
            timer   <= BIT_LOAD;
            uart_tx <= shift[0];
          end else begin
            timer <= timer - TW'(1);
          end
        end
        TX_DATA: begin
          if (timer == '0) begin
            timer <= BIT_LOAD;
            if (idx == 3'd7) begin
              state   <= TX_STOP;
              uart_tx <= 1'b1;
            end else begin
              shift   <= {1'b0, shift[7:1]};
              idx     <= idx + 3'd1;
              uart_tx <= shift[1];
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        TX_STOP: begin
          uart_tx <= 1'b1;
          if (timer == '0) state <= TX_IDLE;
          else             timer <= timer - TW'(1);
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vmicro16_uart_tx_apb.sv
// Bench for vmicro16_uart_tx_apb: APB stimulus, line-level frame monitor and
// a timing/occupancy reference model derived from the frame-pitch rules.
module tb_vmicro16_uart_tx_apb;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;
  localparam int DW      = 16;
  localparam int FRAME   = 10 * CLK_DIV;
  localparam int PITCH   = FRAME + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          psel = 1'b0;
  logic          penable = 1'b0;
  logic          pwrite = 1'b0;
  logic [1:0]    paddr = 2'd0;
  logic [DW-1:0] pwdata = '0;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          uart_tx;

  vmicro16_uart_tx_apb #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (DEPTH),
    .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .S_PSELx   (psel),
    .S_PENABLE (penable),
    .S_PWRITE  (pwrite),
    .S_PADDR   (paddr),
    .S_PWDATA  (pwdata),
    .S_PRDATA  (prdata),
    .S_PREADY  (pready),
    .uart_tx   (uart_tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vecs = 0;
  int errs = 0;

  // Frames observed on the line.
  int         mon_start[$];
  logic [7:0] mon_byte[$];
  bit         mon_shape[$];

  // Reference model: accepted writes with their write and pop cycles.
  int         m_w[$];
  int         m_p[$];
  logic [7:0] m_b[$];
  bit         m_ovf = 1'b0;

  initial begin : monitor
    logic        prev;
    logic [39:0] bits;
    int          s;
    bit          abort;
    bit          shape;
    logic [7:0]  byt;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b1;
      end else if (prev && !uart_tx) begin
        s = cyc;
        bits = '0;
        abort = 1'b0;
        for (int k = 1; k < FRAME && !abort; k++) begin
          @(negedge clk);
          if (reset) abort = 1'b1;
          else bits[k] = uart_tx;
        end
        if (!abort) begin
          shape = 1'b1;
          for (int i = 0; i < 10; i++)
            for (int j = 0; j < CLK_DIV; j++)
              if (bits[CLK_DIV*i+j] !== bits[CLK_DIV*i]) shape = 1'b0;
          if (bits[0] !== 1'b0 || bits[9*CLK_DIV] !== 1'b1) shape = 1'b0;
          for (int i = 0; i < 8; i++) byt[i] = bits[CLK_DIV*(i+1)];
          mon_start.push_back(s);
          mon_byte.push_back(byt);
          mon_shape.push_back(shape);
        end
        prev = 1'b1;
      end else begin
        prev = uart_tx;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors so far", vecs);
    $fatal(1, "timeout");
  end

  function automatic void model_write(int w, logic [7:0] b);
    int cnt;
    bit popnow;
    int p;
    cnt = 0;
    popnow = 1'b0;
    foreach (m_w[k]) begin
      if (m_w[k] < w && m_p[k] >= w) cnt++;
      if (m_p[k] == w) popnow = 1'b1;
    end
    if (cnt >= DEPTH && !popnow) begin
      m_ovf = 1'b1;
    end else begin
      p = w + 1;
      if (m_p.size() > 0 && m_p[$] + PITCH > p) p = m_p[$] + PITCH;
      m_w.push_back(w);
      m_p.push_back(p);
      m_b.push_back(b);
    end
  endfunction

  function automatic logic [15:0] model_status(int r);
    int cnt;
    bit busy;
    logic [15:0] v;
    cnt = 0;
    busy = 1'b0;
    foreach (m_w[k]) begin
      if (m_w[k] < r && m_p[k] >= r) cnt++;
      if (m_p[k] < r && r <= m_p[k] + FRAME) busy = 1'b1;
    end
    v = '0;
    v[7:4] = cnt[3:0];
    v[3] = m_ovf;
    v[2] = busy;
    v[1] = (cnt == 0);
    v[0] = (cnt == DEPTH);
    return v;
  endfunction

  function automatic void model_clear();
    m_w.delete();
    m_p.delete();
    m_b.delete();
    m_ovf = 1'b0;
  endfunction

  task automatic apb_write(input logic [1:0] a, input logic [15:0] d, output int wc);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    wc = cyc;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [1:0] a, output logic [15:0] d, output int rc);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    rc = cyc;
    @(negedge clk);
    d = prdata;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic read_status_vs_model(input string name);
    logic [15:0] d;
    logic [15:0] e;
    int rc;
    apb_read(2'd1, d, rc);
    e = model_status(rc);
    m_ovf = 1'b0;
    vecs++;
    if (d !== e) begin
      errs++;
      $display("FAIL %s: STATUS got %h expected %h (cycle %0d)", name, d, e, rc);
    end
  endtask

  task automatic check_frames(input string name);
    int n;
    int t;
    n = m_b.size();
    t = 0;
    while (mon_byte.size() < n && t < 3000) begin
      @(posedge clk); t++;
    end
    repeat (2 * PITCH + 5) @(posedge clk);
    #1;
    vecs++;
    if (mon_byte.size() != n) begin
      errs++;
      $display("FAIL %s frame count: got %0d expected %0d", name, mon_byte.size(), n);
    end
    for (int k = 0; k < n && k < mon_byte.size(); k++) begin
      vecs++;
      if (mon_byte[k] !== m_b[k]) begin
        errs++;
        $display("FAIL %s frame %0d byte: got %h expected %h", name, k, mon_byte[k], m_b[k]);
      end
      vecs++;
      if (mon_start[k] != m_p[k] + 1) begin
        errs++;
        $display("FAIL %s frame %0d start cycle: got %0d expected %0d", name, k, mon_start[k], m_p[k] + 1);
      end
      vecs++;
      if (mon_shape[k] !== 1'b1) begin
        errs++;
        $display("FAIL %s frame %0d shape: got %0d expected 1", name, k, mon_shape[k]);
      end
    end
    mon_start.delete();
    mon_byte.delete();
    mon_shape.delete();
    model_clear();
  endtask

  task automatic test_reset();
    logic [15:0] d;
    int rc;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
    @(negedge clk);
    vecs++;
    if (uart_tx !== 1'b1) begin errs++; $display("FAIL reset uart_tx: got %b expected 1", uart_tx); end
    vecs++;
    if (pready !== 1'b1) begin errs++; $display("FAIL reset pready: got %b expected 1", pready); end
    vecs++;
    if (prdata !== 16'h0000) begin errs++; $display("FAIL reset prdata idle: got %h expected 0000", prdata); end
    apb_read(2'd1, d, rc);
    vecs++;
    if (d !== 16'h0002) begin errs++; $display("FAIL reset status: got %h expected 0002", d); end
  endtask

  task automatic test_unused();
    logic [15:0] d;
    int rc;
    int wc;
    for (int a = 0; a < 4; a++) begin
      if (a != 1) begin
        apb_read(2'(a), d, rc);
        vecs++;
        if (d !== 16'h0000) begin errs++; $display("FAIL unused read off %0d: got %h expected 0000", a, d); end
      end
    end
    // Setup phase of a STATUS read must not drive data.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 2'd1;
    @(negedge clk);
    vecs++;
    if (prdata !== 16'h0000) begin errs++; $display("FAIL setup-phase read: got %h expected 0000", prdata); end
    // Setup-only write held for several cycles.
    @(posedge clk); #1;
    pwrite = 1'b1; paddr = 2'd0; pwdata = 16'h00AA;
    repeat (3) @(posedge clk);
    #1 psel = 1'b0; pwrite = 1'b0;
    apb_write(2'd2, 16'h0011, wc);
    apb_write(2'd3, 16'h0022, wc);
    read_status_vs_model("setup-only write status");
    check_frames("unused");
  endtask

  task automatic test_single();
    int wc;
    apb_write(2'd0, 16'hFF55, wc);
    model_write(wc, 8'h55);
    read_status_vs_model("single mid-frame status");
    while (cyc < m_p[0] + FRAME - 2) begin @(posedge clk); #1; end
    read_status_vs_model("single last busy cycle");
    read_status_vs_model("single after busy");
    check_frames("single");
  endtask

  task automatic test_back_to_back();
    int wc;
    int t;
    apb_write(2'd0, 16'h00A5, wc);
    model_write(wc, 8'hA5);
    apb_write(2'd0, 16'h003C, wc);
    model_write(wc, 8'h3C);
    t = 0;
    while (mon_byte.size() < 2 && t < 500) begin @(posedge clk); t++; end
    vecs++;
    if (mon_byte.size() < 2) begin
      errs++;
      $display("FAIL b2b wait: got %0d frames expected 2", mon_byte.size());
    end else begin
      if (mon_start[1] - mon_start[0] != PITCH) begin
        errs++;
        $display("FAIL b2b pitch: got %0d expected %0d", mon_start[1] - mon_start[0], PITCH);
      end
      vecs++;
      if (mon_start[1] + FRAME - mon_start[0] != 81) begin
        errs++;
        $display("FAIL b2b total: got %0d expected 81", mon_start[1] + FRAME - mon_start[0]);
      end
    end
    check_frames("back_to_back");
  endtask

  task automatic test_overflow();
    int wc;
    logic [7:0] b;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      apb_write(2'd0, {8'h00, b}, wc);
      model_write(wc, b);
    end
    read_status_vs_model("overflow first read");
    read_status_vs_model("overflow second read");
    check_frames("overflow");
  endtask

  task automatic test_random();
    int wc;
    int n;
    logic [7:0] b;
    for (int burst = 0; burst < 5; burst++) begin
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        b = 8'($urandom);
        apb_write(2'd0, {8'($urandom), b}, wc);
        model_write(wc, b);
        if ($urandom_range(0, 2) == 0) read_status_vs_model("random mid-burst status");
      end
      repeat ($urandom_range(0, 60)) @(posedge clk);
      read_status_vs_model("random post-burst status");
      check_frames("random");
    end
  endtask

  task automatic test_mid_reset();
    int wc;
    logic [15:0] d;
    int rc;
    apb_write(2'd0, 16'h00C3, wc);
    model_write(wc, 8'hC3);
    // Data bit 3 occupies start+16 .. start+19.
    while (cyc < wc + 2 + 4 * CLK_DIV + 1) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vecs++;
    if (uart_tx !== 1'b1) begin errs++; $display("FAIL mid-reset line: got %b expected 1", uart_tx); end
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    apb_read(2'd1, d, rc);
    vecs++;
    if (d !== 16'h0002) begin errs++; $display("FAIL mid-reset status: got %h expected 0002", d); end
    check_frames("mid_reset residual");
  endtask

  initial begin
    test_reset();
    test_unused();
    test_single();
    test_back_to_back();
    test_overflow();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
